// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state, forwarding selects and the grouped stage-strobe struct.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } ctrl_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic ex_mem_flush;
        logic mem_wb_we;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_NORMAL = '{
        pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_we: 1'b1,
        id_ex_flush: 1'b0, ex_mem_we: 1'b1, ex_mem_flush: 1'b0, mem_wb_we: 1'b1
    };

    localparam hazard_ctrl_t CTRL_FREEZE = '{
        pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_we: 1'b0,
        id_ex_flush: 1'b0, ex_mem_we: 1'b0, ex_mem_flush: 1'b0, mem_wb_we: 1'b0
    };

    localparam hazard_ctrl_t CTRL_RESET = '{
        pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_we: 1'b0,
        id_ex_flush: 1'b1, ex_mem_we: 1'b0, ex_mem_flush: 1'b1, mem_wb_we: 1'b0
    };

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                          input logic [4:0] mem_rd,
                                          input logic       mem_reg_write,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_reg_write);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) begin
            return FWD_MEM;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects for both ALU operands.
module pipeline_hazard_ctrl_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with a small
// RUN/REDIR FSM that parks a redirect target while instruction fetch is busy.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             mem_branch_taken,
    input  logic [XLEN-1:0]  mem_target,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             ex_mem_flush,
    output logic             mem_wb_we,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_t      state_q, state_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    hazard_ctrl_t    ctrl;
    logic            pc_sel_c;
    logic [XLEN-1:0] pc_target_c;
    logic            flush_inc;
    logic            dmem_busy;
    logic            load_use;
    logic [1:0]      fwd_a_raw, fwd_b_raw;

    assign dmem_busy = (mem_mem_read | mem_mem_write) & ~dmem_ready;
    assign load_use  = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        ctrl        = CTRL_NORMAL;
        pc_sel_c    = 1'b0;
        pc_target_c = '0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        tgt_d       = tgt_q;
        if (rst) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
            tgt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_busy) begin
                        ctrl = CTRL_FREEZE;
                    end else if (mem_branch_taken) begin
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_flush  = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                        flush_inc         = 1'b1;
                        if (imem_ready) begin
                            pc_sel_c    = 1'b1;
                            pc_target_c = mem_target;
                        end else begin
                            ctrl.pc_we = 1'b0;
                            tgt_d      = mem_target;
                            state_d    = REDIR;
                        end
                    end else if (load_use) begin
                        ctrl.pc_we       = 1'b0;
                        ctrl.if_id_we    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        ctrl.pc_we       = 1'b0;
                        ctrl.if_id_flush = 1'b1;
                    end
                end
                REDIR: begin
                    // Whatever fetch returns here is wrong-path, so IF/ID stays flushed.
                    ctrl.if_id_flush = 1'b1;
                    if (imem_ready) begin
                        pc_sel_c    = 1'b1;
                        pc_target_c = tgt_q;
                        state_d     = RUN;
                    end else begin
                        ctrl.pc_we = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            tgt_q          <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            if (!ctrl.pc_we) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    pipeline_hazard_ctrl_fwd_unit u_fwd_unit (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_we     = ctrl.id_ex_we;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_we    = ctrl.ex_mem_we;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_we    = ctrl.mem_wb_we;
    assign pc_sel       = pc_sel_c;
    assign pc_target    = pc_target_c;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Vector-table bench for pipeline_hazard_ctrl; expected results are queued at
// drive time and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we}
    localparam logic [7:0] E_NORM = 8'hD5;
    localparam logic [7:0] E_FRZ  = 8'h00;
    localparam logic [7:0] E_RST  = 8'h2A;
    localparam logic [7:0] E_LU   = 8'h1D;
    localparam logic [7:0] E_IMS  = 8'h75;
    localparam logic [7:0] E_BRR  = 8'hFF;
    localparam logic [7:0] E_BRW  = 8'h7F;
    localparam logic [7:0] E_REL  = 8'hF5;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
    logic [31:0] mem_target;
    logic        wb_reg_write, imem_ready, dmem_ready;
    logic        pc_we, pc_sel;
    logic [31:0] pc_target;
    logic        if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
        .mem_target(mem_target), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
        .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we), .ex_mem_flush(ex_mem_flush),
        .mem_wb_we(mem_wb_we), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
        logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
        logic [31:0] mem_target;
        logic        wb_reg_write, imem_ready, dmem_ready;
        logic [7:0]  e_ctrl;
        logic        e_pc_sel;
        logic [31:0] e_tgt;
        logic [1:0]  e_fwd_a, e_fwd_b;
        logic        e_redirect;
    } vec_t;

    typedef struct {
        logic        rst;
        logic [7:0]  ctrl;
        logic        pc_sel;
        logic [31:0] tgt;
        logic [1:0]  fwd_a, fwd_b;
        logic [31:0] stall, flush;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          vec_idx = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    function automatic vec_t quiet();
        vec_t v;
        v = '{default: '0};
        v.imem_ready = 1'b1;
        v.dmem_ready = 1'b1;
        v.e_ctrl     = E_NORM;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h, expected %h", vec_idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e, g;
        @(posedge clk);
        #1;
        rst = v.rst;
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        ex_mem_read = v.ex_mem_read; ex_reg_write = v.ex_reg_write;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_reg_write;
        mem_mem_read = v.mem_mem_read; mem_mem_write = v.mem_mem_write;
        mem_branch_taken = v.mem_branch_taken; mem_target = v.mem_target;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_reg_write;
        imem_ready = v.imem_ready; dmem_ready = v.dmem_ready;
        e.rst = v.rst; e.ctrl = v.e_ctrl; e.pc_sel = v.e_pc_sel; e.tgt = v.e_tgt;
        e.fwd_a = v.e_fwd_a; e.fwd_b = v.e_fwd_b; e.stall = m_stall; e.flush = m_flush;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check("ctrl", {24'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                       ex_mem_we, ex_mem_flush, mem_wb_we}, {24'd0, g.ctrl});
        check("pc_sel", {31'd0, pc_sel}, {31'd0, g.pc_sel});
        if (g.pc_sel || g.rst) check("pc_target", pc_target, g.tgt);
        check("fwd_a", {30'd0, fwd_a}, {30'd0, g.fwd_a});
        check("fwd_b", {30'd0, fwd_b}, {30'd0, g.fwd_b});
        check("stall_cycles", stall_cycles, g.stall);
        check("flush_count", flush_count, g.flush);
        if (v.rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!v.e_ctrl[7]) m_stall = m_stall + 1;
            if (v.e_redirect) m_flush = m_flush + 1;
        end
        vec_idx++;
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write} = '0;
        {mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken} = '0;
        mem_target = '0; wb_reg_write = 0; imem_ready = 1; dmem_ready = 1;
        repeat (2) @(posedge clk);

        // Single-cycle vectors, all from RUN.
        v = quiet(); v.rst = 1; v.mem_branch_taken = 1; v.mem_target = 32'h40;
        v.mem_rd = 3; v.ex_rs1 = 3; v.mem_reg_write = 1; v.e_ctrl = E_RST; tbl.push_back(v);
        v = quiet(); tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 5;
        v.id_rs1 = 5; v.id_use_rs1 = 1; v.e_ctrl = E_LU; tbl.push_back(v);
        v = quiet(); v.wb_rd = 5; v.wb_reg_write = 1; v.ex_rs1 = 5; v.e_fwd_a = 2'b01;
        tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 6;
        v.id_rs1 = 9; v.id_rs2 = 6; v.id_use_rs1 = 1; v.id_use_rs2 = 1; v.e_ctrl = E_LU;
        tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 6;
        v.id_rs2 = 6; v.id_use_rs1 = 1; tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 0; v.id_rs1 = 0;
        v.id_use_rs1 = 1; v.mem_rd = 0; v.ex_rs1 = 0; v.mem_reg_write = 1; tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_rd = 4; v.id_rs1 = 4; v.id_use_rs1 = 1;
        tbl.push_back(v);
        v = quiet(); v.mem_rd = 7; v.wb_rd = 7; v.ex_rs2 = 7; v.mem_reg_write = 1;
        v.wb_reg_write = 1; v.e_fwd_b = 2'b10; tbl.push_back(v);
        v = quiet(); v.mem_rd = 3; v.wb_rd = 3; v.ex_rs1 = 3; v.mem_reg_write = 1;
        v.e_fwd_a = 2'b10; tbl.push_back(v);
        v = quiet(); v.imem_ready = 0; v.e_ctrl = E_IMS; tbl.push_back(v);
        v = quiet(); v.mem_branch_taken = 1; v.mem_target = 32'h100; v.e_ctrl = E_BRR;
        v.e_pc_sel = 1; v.e_tgt = 32'h100; v.e_redirect = 1; tbl.push_back(v);
        v = quiet(); v.mem_mem_read = 1; v.dmem_ready = 0; v.mem_branch_taken = 1;
        v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
        v.e_ctrl = E_FRZ; tbl.push_back(v);
        v = quiet(); v.mem_mem_write = 1; v.dmem_ready = 0; v.e_ctrl = E_FRZ; tbl.push_back(v);
        v = quiet(); v.mem_mem_read = 1; tbl.push_back(v);
        v = quiet(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 8; v.id_rs2 = 8;
        v.id_use_rs2 = 1; v.imem_ready = 0; v.e_ctrl = E_LU; tbl.push_back(v);
        run_tbl();

        // Redirect while fetch is busy; target change during REDIR must be ignored.
        v = quiet(); v.mem_branch_taken = 1; v.mem_target = 32'h100; v.imem_ready = 0;
        v.e_ctrl = E_BRW; v.e_redirect = 1; tbl.push_back(v);
        v = quiet(); v.mem_branch_taken = 1; v.mem_target = 32'h200; v.imem_ready = 0;
        v.e_ctrl = E_IMS; tbl.push_back(v);
        v = quiet(); v.mem_target = 32'h200; v.imem_ready = 0; v.e_ctrl = E_IMS;
        tbl.push_back(v);
        v = quiet(); v.mem_target = 32'h200; v.e_ctrl = E_REL; v.e_pc_sel = 1;
        v.e_tgt = 32'h100; tbl.push_back(v);
        v = quiet(); tbl.push_back(v);
        run_tbl();

        // Data-memory wait states with a load-use hazard pending behind them.
        for (int i = 0; i < 2; i++) begin
            v = quiet(); v.mem_mem_read = 1; v.dmem_ready = 0; v.ex_mem_read = 1;
            v.ex_reg_write = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1; v.e_ctrl = E_FRZ;
            tbl.push_back(v);
        end
        v = quiet(); v.mem_mem_read = 1; v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_rd = 5;
        v.id_rs1 = 5; v.id_use_rs1 = 1; v.e_ctrl = E_LU; tbl.push_back(v);
        v = quiet(); tbl.push_back(v);
        run_tbl();

        // Reset while parked in REDIR must drop back to RUN with cleared counters.
        v = quiet(); v.mem_branch_taken = 1; v.mem_target = 32'h300; v.imem_ready = 0;
        v.e_ctrl = E_BRW; v.e_redirect = 1; tbl.push_back(v);
        v = quiet(); v.rst = 1; v.imem_ready = 0; v.mem_rd = 7; v.ex_rs2 = 7;
        v.mem_reg_write = 1; v.e_ctrl = E_RST; tbl.push_back(v);
        v = quiet(); tbl.push_back(v);
        v = quiet(); v.imem_ready = 0; v.e_ctrl = E_IMS; tbl.push_back(v);
        v = quiet(); tbl.push_back(v);
        run_tbl();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got %0d leftover entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RV32IC pipeline (IF, ID, EX, MEM, WB).
- Issues per-stage write-enable and flush (bubble) strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branches/jumps resolved in MEM, and instruction/data memory wait states.
- Generates EX-stage operand forwarding selects and exposes stall and flush performance counters.

Parameters:
XLEN, 32, address/target width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_rs1, id_rs2  in  5  ID-stage source registers
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5  EX-stage source registers (ID/EX)
ex_rd  in  5  EX destination
ex_mem_read, ex_reg_write  in  1  EX control bits
mem_rd  in  5  MEM destination
mem_reg_write, mem_mem_read, mem_mem_write  in  1  MEM control bits
mem_branch_taken  in  1  BranchSrc0 & branch, redirect request from MEM
mem_target  in  XLEN  redirect target (AddSum)
wb_rd  in  5  WB destination
wb_reg_write  in  1  WB control bit
imem_ready  in  1  fetch data valid this cycle
dmem_ready  in  1  data access completes this cycle
pc_we, pc_sel  out  1  PC load enable; 1 selects pc_target over PC+step
pc_target  out  XLEN  redirect address
if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we  out  1  stage enables/bubbles (flush dominates we)
fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 WB, 10 MEM
stall_cycles  out  CNT_W  cycles with pc_we=0 (excluding reset)
flush_count  out  CNT_W  number of redirects taken

Behaviour:
- FSM states: RUN, REDIR. Registers: state, tgt_q (XLEN), both counters.
- rst=1 (sync, dominates everything): next state RUN, tgt_q=0, counters=0. Outputs while rst high: all *_we=0, all flushes=1, pc_sel=0, pc_target=0, fwd=00.
- dmem_busy = (mem_mem_read|mem_mem_write) & !dmem_ready.
- Event priority in RUN: dmem_busy > redirect > load-use > imem stall > normal.
- Normal: all we=1, flushes=0, pc_sel=0.
- dmem_busy: full freeze; every we=0, no flushes. WB re-presents the same write, which is idempotent. No state change.
- Redirect (mem_branch_taken, not dmem_busy):
  - Flush IF/ID, ID/EX and EX/MEM; mem_wb_we=1; flush_count+1.
  - imem_ready=1: pc_sel=1, pc_target=mem_target, pc_we=1, stay RUN.
  - imem_ready=0: pc_we=0, tgt_q<=mem_target, go REDIR.
- Load-use: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1. Exactly one bubble per hazard.
- imem stall (imem_ready=0, no higher event): pc_we=0, if_id_flush=1, downstream advances.
- REDIR:
  - Each cycle: pc_we=0, if_id_flush=1, rest we=1. dmem_busy and redirect cannot occur here because younger stages were flushed.
  - On imem_ready=1: returned (wrong-path) word is discarded via if_id_flush=1; pc_sel=1, pc_target=tgt_q, pc_we=1; go RUN.
  - Later changes on mem_target are ignored.
- Forwarding (combinational):
  - fwd_a = 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00.
  - fwd_b: same rule using ex_rs2. MEM has priority over WB.
- Counters: stall_cycles increments on every non-reset cycle with pc_we=0. Both counters wrap modulo 2^CNT_W.

Decomposition:
- Package PipelineCtrl holds:
  - ctrl_state_t enum {RUN, REDIR}
  - fwd_sel_t constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - hazard_ctrl_t packed struct grouping all we/flush outputs
- One sub-module, fwd_unit: purely combinational, instantiated once and feeds both fwd_a and fwd_b.

Test Plan:
- Load-use: ex lw rd=5, ID add rs1=5 use_rs1=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1. Next cycle (wb_rd=5, ex_rs1=5) fwd_a=01. stall_cycles=1.
- x0 guard: ex lw rd=0, id rs1=0 -> no stall. Also mem_rd=0=ex_rs1 with mem_reg_write -> fwd_a=00.
- Taken branch, imem_ready=1, mem_target=0x00000100 -> same cycle pc_sel=1, pc_target=0x100, if_id/id_ex/ex_mem flush=1, flush_count 0->1, stays RUN.
- Taken branch at T, imem_ready low T..T+2, mem_target changed to 0x200 at T+1 -> REDIR T+1..T+2. At T+3 pc_target=0x100, pc_sel=1, if_id_flush=1. stall_cycles=3.
- Load in MEM with dmem_ready=0 for 2 cycles plus a pending load-use in ID -> 2 cycles all we=0, no flush. Then a 1-cycle load-use bubble.
- rst=1 during REDIR -> next cycle state RUN, counters=0, pc_sel=0. Forward-priority check: mem_rd=wb_rd=ex_rs2=7, both write -> fwd_b=10.
